// File: rtl/alu_regfile_pkg.sv
// Shared constants for the MIPS architectural register file and its flag register.
package alu_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // Bit positions inside the 4-bit Flags register: {N, C, V, Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_W = 4;

  // Architectural zero register index
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_decoder.sv
// One-hot write-enable decoder; the zero-register line is never asserted.
module regfile_decoder #(
  parameter int unsigned ADDR_W = alu_regfile_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] sel_c
);
  import alu_regfile_pkg::*;

  // Decode write address to one-hot enables, with line 0 forced low
  always_comb begin
    sel_c = '0;
    if (en) begin
      sel_c[addr] = 1'b1;
    end
    sel_c[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/alu_regfile.sv
// Architectural register file with two combinational read ports, one write
// port and a 4-bit ALU status register.
// Optional macro ALU_REGFILE_BYPASS_EN: write-through bypass from WriteData to
// a read port addressing the register being written in the same cycle.
module alu_regfile #(
  parameter int unsigned DATA_W = alu_regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = alu_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] BussA,
  output logic [DATA_W-1:0] BussB,
  input  logic              FlagWrite,
  input  logic              ZeroIn,
  input  logic              OverflowIn,
  input  logic              CarryIn,
  input  logic              NegativeIn,
  output logic [3:0]        Flags
);
  import alu_regfile_pkg::*;

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  we_c;
  logic [DATA_W-1:0] raw_a_c;
  logic [DATA_W-1:0] raw_b_c;
  logic              zero_a_c;
  logic              zero_b_c;

  regfile_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr  (WriteReg),
    .en    (RegWrite),
    .sel_c (we_c)
  );

  // Register storage: synchronous clear, decoded write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (we_c[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // Per-bit read multiplexers, one column of DEPTH bits per data bit
  for (genvar b = 0; b < int'(DATA_W); b++) begin : g_bit
    logic [DEPTH-1:0] col;
    for (genvar r = 0; r < int'(DEPTH); r++) begin : g_row
      assign col[r] = regs[r][b];
    end
    assign raw_a_c[b] = col[ReadReg1];
    assign raw_b_c[b] = col[ReadReg2];
  end

  assign zero_a_c = (ReadReg1 == ADDR_W'(ZERO_REG));
  assign zero_b_c = (ReadReg2 == ADDR_W'(ZERO_REG));

`ifdef ALU_REGFILE_BYPASS_EN
  logic byp_a_c;
  logic byp_b_c;

  // Forward in-flight write data; address 0 reads as zero regardless
  assign byp_a_c = RegWrite && (WriteReg != ADDR_W'(ZERO_REG)) && (ReadReg1 == WriteReg);
  assign byp_b_c = RegWrite && (WriteReg != ADDR_W'(ZERO_REG)) && (ReadReg2 == WriteReg);
  assign BussA   = zero_a_c ? '0 : (byp_a_c ? WriteData : raw_a_c);
  assign BussB   = zero_b_c ? '0 : (byp_b_c ? WriteData : raw_b_c);
`else
  // Stored value only; address 0 reads as zero even before first reset
  assign BussA = zero_a_c ? '0 : raw_a_c;
  assign BussB = zero_b_c ? '0 : raw_b_c;
`endif

  // Status flag capture from the ALU
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Flags <= '0;
    end else if (FlagWrite) begin
      Flags[FLAG_N] <= NegativeIn;
      Flags[FLAG_C] <= CarryIn;
      Flags[FLAG_V] <= OverflowIn;
      Flags[FLAG_Z] <= ZeroIn;
    end
  end

  // A write with an unknown destination would corrupt an unknown register
  a_waddr_known: assert property (@(posedge clk) disable iff (!rst_n)
    RegWrite |-> !$isunknown(WriteReg));

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: stimulus pushes expected bus/flag values,
// a monitor pops and compares them at the falling edge.
module tb_alu_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ReadReg1, ReadReg2, WriteReg;
  logic [DW-1:0] WriteData;
  logic          RegWrite;
  logic [DW-1:0] BussA, BussB;
  logic          FlagWrite, ZeroIn, OverflowIn, CarryIn, NegativeIn;
  logic [3:0]    Flags;

  alu_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .BussA      (BussA),
    .BussB      (BussB),
    .FlagWrite  (FlagWrite),
    .ZeroIn     (ZeroIn),
    .OverflowIn (OverflowIn),
    .CarryIn    (CarryIn),
    .NegativeIn (NegativeIn),
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned sel;   // 0 = BussA, 1 = BussB, 2 = Flags
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Monitor: compare every pending expectation against the DUT outputs
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = BussA;
        1:       act = BussB;
        default: act = {28'h0, Flags};
      endcase
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = 0; e.exp = v;
    q.push_back(e);
  endtask

  task automatic exp_b(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = 1; e.exp = v;
    q.push_back(e);
  endtask

  task automatic exp_f(input string n, input logic [3:0] v);
    exp_t e;
    e.name = n; e.sel = 2; e.exp = {28'h0, v};
    q.push_back(e);
  endtask

  task automatic set_flags_in(input logic [3:0] nczv);
    NegativeIn = nczv[3];
    CarryIn    = nczv[2];
    OverflowIn = nczv[1];
    ZeroIn     = nczv[0];
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    tick();
    RegWrite  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; WriteData = '0;
    RegWrite = 1'b0; FlagWrite = 1'b0;
    set_flags_in(4'b0000);
    tick();
    tick();
    rst_n = 1'b1;

    // Preload R5 and Flags
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h0000_1234;
    FlagWrite = 1'b1; set_flags_in(4'b1111);
    tick();
    RegWrite = 1'b0; FlagWrite = 1'b0; set_flags_in(4'b0000);
    ReadReg1 = 5'd5; ReadReg2 = 5'd5;
    exp_a("preload_r5", 32'h0000_1234);
    exp_f("preload_flags", 4'b1111);

    // rst_n pulsed low between edges must not reset anything
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_a("glitch_r5_same_cycle", 32'h0000_1234);
    tick();
    exp_a("glitch_r5_after_edge", 32'h0000_1234);
    exp_f("glitch_flags_after_edge", 4'b1111);

    // Synchronous reset; write and flag capture in the reset cycle are ignored
    tick();
    rst_n = 1'b0;
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h0000_AAAA;
    FlagWrite = 1'b1; set_flags_in(4'b0110);
    tick();
    rst_n = 1'b1; RegWrite = 1'b0; FlagWrite = 1'b0;
    exp_a("reset_r5", 32'h0);
    exp_b("reset_r5_b", 32'h0);
    exp_f("reset_flags", 4'b0000);

    // Write then read the same register on both ports
    tick();
    wr(5'd7, 32'hDEAD_BEEF);
    ReadReg1 = 5'd7; ReadReg2 = 5'd7; WriteData = 32'h1;
    exp_a("r7_a", 32'hDEAD_BEEF);
    exp_b("r7_b", 32'hDEAD_BEEF);
    WriteReg = 5'd7;
    tick();
    exp_a("r7_hold_no_we", 32'hDEAD_BEEF);

    // Register 0 write is discarded, same cycle and after the edge
    tick();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    exp_a("r0_during_write", 32'h0);
    exp_b("r0_during_write_b", 32'h0);
    tick();
    RegWrite = 1'b0;
    exp_a("r0_after_write", 32'h0);

    // Same-cycle read/write of R3
    tick();
    wr(5'd3, 32'h10);
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h20; ReadReg1 = 5'd3;
`ifdef ALU_REGFILE_BYPASS_EN
    exp_a("r3_same_cycle", 32'h20);
`else
    exp_a("r3_same_cycle", 32'h10);
`endif
    tick();
    RegWrite = 1'b0;
    exp_a("r3_after_edge", 32'h20);

    // Flag capture and hold
    tick();
    FlagWrite = 1'b1; set_flags_in(4'b1010);
    tick();
    FlagWrite = 1'b0; set_flags_in(4'b0101);
    exp_f("flags_capture", 4'b1010);
    tick();
    exp_f("flags_hold", 4'b1010);

    // Simultaneous register write and flag capture
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hCAFE_0009;
    FlagWrite = 1'b1; set_flags_in(4'b0110);
    tick();
    RegWrite = 1'b0; FlagWrite = 1'b0; ReadReg2 = 5'd9;
    exp_b("dual_r9", 32'hCAFE_0009);
    exp_f("dual_flags", 4'b0110);

    // Sweep: fill R1..R31, then read mirrored pairs
    tick();
    for (int i = 1; i < 32; i++) begin
      wr(AW'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = AW'(i);
      ReadReg2 = AW'(31 - i);
      exp_a($sformatf("sweep_a_r%0d", i), 32'(i) * 32'h0101_0101);
      exp_b($sformatf("sweep_b_r%0d", 31 - i), 32'(31 - i) * 32'h0101_0101);
      tick();
    end

    // Bounded drain of the scoreboard
    for (int k = 0; k < 5 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
